// File: rtl/dig_clock_pkg.sv
// Shared types, limits and BCD/12-hour helpers for the digital clock core.
package dig_clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam logic [4:0] HR_MAX  = 5'd23;
  localparam logic [5:0] MIN_MAX = 6'd59;

  function automatic bcd2_t to_bcd2(input logic [5:0] v);
    bcd2_t r;
    r.tens = 4'(v / 6'd10);
    r.ones = 4'(v % 6'd10);
    return r;
  endfunction

  function automatic logic [4:0] hr_to_12(input logic [4:0] h);
    if (h == 5'd0)       return 5'd12;
    else if (h > 5'd12)  return h - 5'd12;
    else                 return h;
  endfunction

endpackage

// File: rtl/btn_repeat.sv
// Button edge/auto-repeat unit: pulse on press, again after RPT_DLY, then every RPT_PER.
module btn_repeat #(
  parameter int RPT_DLY = 50_000_000,
  parameter int RPT_PER = 10_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int MAXC = (RPT_DLY > RPT_PER) ? RPT_DLY : RPT_PER;
  localparam int CW   = $clog2(MAXC + 1);

  logic          btn_q;
  logic          lock;
  logic          rep;
  logic [CW-1:0] cnt;
  logic          due;

  always_comb begin
    due   = rep ? (cnt == CW'(RPT_PER)) : (cnt == CW'(RPT_DLY));
    pulse = btn & ~lock & (~btn_q | due);
  end

  // lock keeps a button held through reset silent until it is released
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_q <= 1'b0;
      lock  <= 1'b1;
      rep   <= 1'b0;
      cnt   <= '0;
    end else if (!btn) begin
      btn_q <= 1'b0;
      lock  <= 1'b0;
      rep   <= 1'b0;
      cnt   <= '0;
    end else if (!lock) begin
      btn_q <= 1'b1;
      if (pulse) begin
        cnt <= CW'(1);
        rep <= btn_q;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/dig_clock_alarm.sv
// Clock core with settable time, 12/24-hour display, and one alarm with latched ring.
module dig_clock_alarm
  import dig_clock_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000,
  parameter int RPT_DLY  = 50_000_000,
  parameter int RPT_PER  = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       adv_hr,
  input  logic       adv_min,
  input  logic       mode_24,
  input  logic       run,
  input  logic       alarm_set,
  input  logic       alarm_en,
  output logic [3:0] h1,
  output logic [3:0] h0,
  output logic [3:0] m1,
  output logic [3:0] m0,
  output logic [3:0] s1,
  output logic [3:0] s0,
  output logic       pm,
  output logic       sec_tick,
  output logic       alarm_ring
);

  localparam int            PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  function automatic logic [4:0] inc_hr(input logic [4:0] h);
    return (h == HR_MAX) ? 5'd0 : h + 5'd1;
  endfunction

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == MIN_MAX) ? 6'd0 : m + 6'd1;
  endfunction

  logic          hr_pulse, min_pulse, set_pulse, time_edit, tick, edit_q;
  logic [PW-1:0] presc;
  logic [4:0]    hr, al_hr, sel_hr, disp_hr;
  logic [5:0]    min, sec, al_min, sel_min, sel_sec;
  bcd2_t         hr_d, min_d, sec_d;

  btn_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_rpt_hr (
    .clk(clk), .rst(rst), .btn(adv_hr), .pulse(hr_pulse)
  );

  btn_repeat #(.RPT_DLY(RPT_DLY), .RPT_PER(RPT_PER)) u_rpt_min (
    .clk(clk), .rst(rst), .btn(adv_min), .pulse(min_pulse)
  );

  assign set_pulse = hr_pulse | min_pulse;
  assign time_edit = set_pulse & ~alarm_set;
  assign tick      = run & (presc == PRE_LAST) & ~time_edit;

  // Stage 0: timekeeping and alarm registers
  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      hr       <= '0;
      min      <= '0;
      sec      <= '0;
      al_hr    <= '0;
      al_min   <= '0;
      sec_tick <= 1'b0;
      edit_q   <= 1'b0;
    end else begin
      sec_tick <= tick;
      edit_q   <= set_pulse;
      if (min_pulse && !alarm_set)
        presc <= '0;
      else if (run)
        presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
      if (tick) begin
        sec <= inc_min(sec);
        if (sec == MIN_MAX) begin
          min <= inc_min(min);
          if (min == MIN_MAX) hr <= inc_hr(hr);
        end
      end else if (!alarm_set) begin
        if (hr_pulse) hr <= inc_hr(hr);
        if (min_pulse) begin
          min <= inc_min(min);
          sec <= '0;
        end
      end
      if (alarm_set) begin
        if (hr_pulse)  al_hr  <= inc_hr(al_hr);
        if (min_pulse) al_min <= inc_min(al_min);
      end
    end
  end

  always_comb begin
    sel_hr  = alarm_set ? al_hr  : hr;
    sel_min = alarm_set ? al_min : min;
    sel_sec = alarm_set ? 6'd0   : sec;
    disp_hr = mode_24 ? sel_hr : hr_to_12(sel_hr);
    hr_d    = to_bcd2({1'b0, disp_hr});
    min_d   = to_bcd2(sel_min);
    sec_d   = to_bcd2(sel_sec);
  end

  // Stage 1: registered display and ring; ring only latches on a real tick, never on an edit
  always_ff @(posedge clk) begin
    if (rst) begin
      h1         <= mode_24 ? 4'd0 : 4'd1;
      h0         <= mode_24 ? 4'd0 : 4'd2;
      m1         <= 4'd0;
      m0         <= 4'd0;
      s1         <= 4'd0;
      s0         <= 4'd0;
      pm         <= 1'b0;
      alarm_ring <= 1'b0;
    end else begin
      h1 <= hr_d.tens;
      h0 <= hr_d.ones;
      m1 <= min_d.tens;
      m0 <= min_d.ones;
      s1 <= sec_d.tens;
      s0 <= sec_d.ones;
      pm <= ~mode_24 & (sel_hr >= 5'd12);
      if (!alarm_en || set_pulse || (min != al_min))
        alarm_ring <= 1'b0;
      else if (sec_tick && !edit_q && (sec == 6'd0) && (hr == al_hr))
        alarm_ring <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dig_clock_alarm.sv
// Bench for dig_clock_alarm: directed scenarios plus random traffic against a seconds-of-day model.
module tb_dig_clock_alarm;

  localparam int TD  = 4;
  localparam int DLY = 8;
  localparam int PER = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, adv_hr, adv_min, mode_24, run, alarm_set, alarm_en;
  logic [3:0] h1, h0, m1, m0, s1, s0;
  logic pm, sec_tick, alarm_ring;
  logic [23:0] dig;
  assign dig = {h1, h0, m1, m0, s1, s0};

  dig_clock_alarm #(.TICK_DIV(TD), .RPT_DLY(DLY), .RPT_PER(PER)) dut (
    .clk(clk), .rst(rst), .adv_hr(adv_hr), .adv_min(adv_min), .mode_24(mode_24),
    .run(run), .alarm_set(alarm_set), .alarm_en(alarm_en),
    .h1(h1), .h0(h0), .m1(m1), .m0(m0), .s1(s1), .s0(s0),
    .pm(pm), .sec_tick(sec_tick), .alarm_ring(alarm_ring)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference state: time as seconds of day, alarm as minutes of day
  int          t_s, al_m, pre;
  bit          m_tick, m_ring, m_edit;
  logic [24:0] m_disp;
  int          held[2];
  bit          lock[2];

  function automatic logic [24:0] disp_of(input int hh, input int mm, input int ss, input bit m24);
    int hd;
    hd = m24 ? hh : ((hh % 12 == 0) ? 12 : hh % 12);
    return {4'(hd / 10), 4'(hd % 10), 4'(mm / 10), 4'(mm % 10),
            4'(ss / 10), 4'(ss % 10), 1'(!m24 && hh >= 12)};
  endfunction

  task automatic step();
    bit p[2];
    bit btn[2];
    bit tick;
    int hh, mm, ss, ah, am;
    btn[0] = adv_hr;
    btn[1] = adv_min;
    if (rst) begin
      t_s = 0; al_m = 0; pre = 0;
      m_tick = 0; m_ring = 0; m_edit = 0;
      m_disp = disp_of(0, 0, 0, mode_24);
      for (int b = 0; b < 2; b++) begin held[b] = 0; lock[b] = 1; end
    end else begin
      for (int b = 0; b < 2; b++) begin
        p[b] = 0;
        if (!btn[b]) begin
          held[b] = 0; lock[b] = 0;
        end else if (!lock[b]) begin
          p[b] = (held[b] == 0) || (held[b] >= DLY && (held[b] - DLY) % PER == 0);
          held[b]++;
        end
      end
      hh = t_s / 3600; mm = (t_s / 60) % 60; ss = t_s % 60;
      ah = al_m / 60;  am = al_m % 60;
      m_disp = alarm_set ? disp_of(ah, am, 0, mode_24) : disp_of(hh, mm, ss, mode_24);
      if (!alarm_en || p[0] || p[1] || mm != am) m_ring = 0;
      else if (m_tick && !m_edit && ss == 0 && t_s / 60 == al_m) m_ring = 1;
      tick = run && pre == TD - 1 && !(!alarm_set && (p[0] || p[1]));
      if (!alarm_set && p[1]) pre = 0;
      else if (run) pre = (pre + 1) % TD;
      if (tick) t_s = (t_s + 1) % 86400;
      else if (!alarm_set) begin
        if (p[0]) hh = (hh + 1) % 24;
        if (p[1]) begin mm = (mm + 1) % 60; ss = 0; end
        t_s = hh * 3600 + mm * 60 + ss;
      end
      if (alarm_set) begin
        if (p[0]) ah = (ah + 1) % 24;
        if (p[1]) am = (am + 1) % 60;
        al_m = ah * 60 + am;
      end
      m_tick = tick;
      m_edit = p[0] || p[1];
    end
    @(posedge clk);
    @(negedge clk);
    chk("disp", {7'b0, dig, pm}, {7'b0, m_disp});
    chk("sec_tick", {31'b0, sec_tick}, {31'b0, m_tick});
    chk("ring", {31'b0, alarm_ring}, {31'b0, m_ring});
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic tap(input bit hr_btn, input int n);
    for (int i = 0; i < n; i++) begin
      if (hr_btn) adv_hr = 1'b1; else adv_min = 1'b1;
      step();
      adv_hr = 1'b0; adv_min = 1'b0;
      step();
    end
  endtask

  initial begin
    rst = 1; adv_hr = 0; adv_min = 0; mode_24 = 0; run = 0; alarm_set = 0; alarm_en = 0;
    steps(2);
    chk("rst_dig", dig, 24'h120000);
    chk("rst_pm", pm, 0);

    // first second after reset
    rst = 0; run = 1;
    steps(3);
    chk("tick_early", sec_tick, 0);
    step();
    chk("tick_1s", sec_tick, 1);
    step();
    chk("dig_1s_12h", dig, 24'h120001);
    mode_24 = 1;
    step();
    chk("dig_1s_24h", dig, 24'h000001);

    // preload 23:59:59 and roll over midnight
    mode_24 = 0; run = 0;
    tap(0, 59);
    tap(1, 23);
    run = 1;
    steps(236);
    step();
    chk("dig_235959", dig, 24'h115959);
    chk("pm_235959", pm, 1);
    steps(3);
    chk("tick_midnight", sec_tick, 1);
    step();
    chk("dig_midnight", dig, 24'h120000);
    chk("pm_midnight", pm, 0);

    // held minute button auto-repeats five times in 20 cycles
    run = 0;
    adv_min = 1;
    steps(20);
    adv_min = 0;
    steps(2);
    chk("dig_rpt5", dig, 24'h120500);
    adv_min = 1;
    step();
    adv_min = 0;
    step();
    chk("dig_repress", dig, 24'h120600);

    // hour pulse coincident with a tick swallows the tick
    run = 1;
    steps(3);
    adv_hr = 1;
    step();
    chk("hr_tick_lost", sec_tick, 0);
    adv_hr = 0; run = 0;
    step();
    chk("dig_0106", dig, 24'h010600);
    tap(1, 12);
    step();
    chk("dig_13h", dig, 24'h010600);
    chk("pm_13h", pm, 1);

    // alarm 00:01, ring set and cleared by minute change
    alarm_set = 1;
    tap(0, 1);
    step();
    chk("dig_alarm", dig, 24'h120100);
    alarm_set = 0;
    tap(1, 11);
    tap(0, 54);
    alarm_en = 1; run = 1;
    steps(232);
    steps(8);
    chk("ring_not_yet", alarm_ring, 0);
    step();
    chk("ring_set", alarm_ring, 1);
    steps(239);
    chk("ring_hold", alarm_ring, 1);
    step();
    chk("ring_min_clr", alarm_ring, 0);

    // editing time onto the alarm must not ring; then ring and drop alarm_en
    run = 0;
    tap(0, 59);
    step();
    chk("dig_edit_match", dig, 24'h120100);
    chk("ring_edit_match", alarm_ring, 0);
    tap(0, 59);
    run = 1;
    steps(240);
    step();
    chk("ring_set2", alarm_ring, 1);
    alarm_en = 0;
    step();
    chk("ring_en_clr", alarm_ring, 0);
    alarm_en = 1;
    steps(4);
    chk("ring_no_reset", alarm_ring, 0);

    // reset during a held, repeating button
    run = 0;
    adv_hr = 1;
    steps(10);
    rst = 1;
    step();
    chk("rst2_dig", dig, 24'h120000);
    chk("rst2_pm", pm, 0);
    chk("rst2_tick", sec_tick, 0);
    chk("rst2_ring", alarm_ring, 0);
    rst = 0;
    steps(15);
    chk("held_after_rst", dig, 24'h120000);
    adv_hr = 0;
    step();
    adv_hr = 1;
    step();
    adv_hr = 0;
    step();
    chk("fresh_press", dig, 24'h010000);

    // random traffic
    run = 1;
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      if (adv_hr) adv_hr = ($urandom_range(0, 11) != 0);
      else        adv_hr = ($urandom_range(0, 19) == 0);
      if (adv_min) adv_min = ($urandom_range(0, 11) != 0);
      else         adv_min = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) mode_24 = ~mode_24;
      if ($urandom_range(0, 49) == 0) run = ~run;
      if ($urandom_range(0, 79) == 0) alarm_set = ~alarm_set;
      if ($urandom_range(0, 99) == 0) alarm_en = ~alarm_en;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
